plru_state_array: RTL and testbench

Per-set storage for the 3-bit tree pseudo-LRU state and per-way valid bits of the set-associative cache. It sits directly upstream and downstream of the combinational PLRU update/decision logic. On a lookup it supplies that logic's current state, the set's valid bits and a registered miss victim. It then writes back the updated state the logic produces. After reset or flush it runs an initialisation sweep that clears every set.

---
 rtl/cache_pkg.sv | 46 ++++
 rtl/plru_state_array.sv | 131 +++++++++++++
 tb/tb_plru_state_array.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared cache definitions: PLRU state type, one-hot way constants, the
// array controller FSM encoding and the victim-selection function used by
// both the state array and the PLRU decision logic.
package cache_pkg;

    typedef logic [2:0] plru_state_t;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } arr_state_t;

    localparam plru_state_t PLRU_INIT = 3'b000;

    localparam logic [3:0] WAY_A = 4'b0001;
    localparam logic [3:0] WAY_B = 4'b0010;
    localparam logic [3:0] WAY_C = 4'b0100;
    localparam logic [3:0] WAY_D = 4'b1000;

    // Pick the replacement way: lowest invalid way first, otherwise decode
    // the tree state. Ways at or above num_ways do not exist and are treated
    // as valid so they can never be chosen.
    function automatic logic [3:0] plru_victim(
        input plru_state_t state,
        input logic [3:0]  valid,
        input int          num_ways
    );
        logic [3:0] v_eff;
        v_eff = valid;
        for (int i = 0; i < 4; i++) begin
            if (i >= num_ways) v_eff[i] = 1'b1;
        end

        if (num_ways <= 1)      plru_victim = WAY_A;
        else if (!v_eff[0])     plru_victim = WAY_A;
        else if (!v_eff[1])     plru_victim = WAY_B;
        else if (!v_eff[2])     plru_victim = WAY_C;
        else if (!v_eff[3])     plru_victim = WAY_D;
        else if (num_ways == 2) plru_victim = state[0] ? WAY_A : WAY_B;
        else if (state[1:0] == 2'b11) plru_victim = WAY_A;
        else if (state[1:0] == 2'b01) plru_victim = WAY_B;
        else if (state[2])      plru_victim = WAY_C;
        else                    plru_victim = WAY_D;
    endfunction

endpackage

// File: rtl/plru_state_array.sv
// Per-set PLRU tree state and way-valid storage. Serves one lookup and one
// write-back per cycle with write-first bypass, registers the replacement
// victim alongside the lookup data, and clears every set with a sweep after
// reset or flush.
import cache_pkg::*;

module plru_state_array #(
    parameter  int NUM_SETS = 16,
    parameter  int NUM_WAYS = 4,
    localparam int S_IDX    = $clog2(NUM_SETS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                rd_en,
    input  logic [S_IDX-1:0]    rd_set,
    input  logic                upd_en,
    input  logic [S_IDX-1:0]    upd_set,
    input  logic [2:0]          upd_state,
    input  logic [NUM_WAYS-1:0] upd_way,
    output logic                ready,
    output logic                rd_valid,
    output logic [2:0]          lru_curstate,
    output logic [NUM_WAYS-1:0] valid_out,
    output logic [NUM_WAYS-1:0] victim_way
);

    arr_state_t          r_state;
    arr_state_t          w_next_state;
    logic [S_IDX-1:0]    r_cnt;

    plru_state_t         r_lru   [NUM_SETS];
    logic [NUM_WAYS-1:0] r_valid [NUM_SETS];

    logic                w_sweep_wr;
    logic                w_upd_wr;
    logic                w_rd_fire;
    logic                w_bypass;
    plru_state_t         w_rd_state;
    logic [NUM_WAYS-1:0] w_rd_valid_bits;
    logic [3:0]          w_valid4;
    logic [3:0]          w_victim4;

    logic                r_rd_valid;
    plru_state_t         r_lru_out;
    logic [NUM_WAYS-1:0] r_valid_out;
    logic [NUM_WAYS-1:0] r_victim_out;

    // FSM state register.
    // NOTE: sequential state always uses non-blocking (<=) so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_INIT;
        else        r_state <= w_next_state;
    end

    // FSM next-state: sweep ends on the last set, flush always restarts it.
    // NOTE: the default assignment at the top keeps this block latch-free.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_INIT: begin
                if (!flush && r_cnt == S_IDX'(NUM_SETS - 1)) w_next_state = ST_READY;
            end
            ST_READY: begin
                if (flush) w_next_state = ST_INIT;
            end
            default: w_next_state = ST_INIT;
        endcase
    end

    // FSM outputs: request qualification; flush drops any same-cycle update.
    always_comb begin
        ready      = (r_state == ST_READY);
        w_sweep_wr = (r_state == ST_INIT) && !flush;
        w_upd_wr   = ready && upd_en && !flush;
        w_rd_fire  = ready && rd_en;
    end

    // Sweep counter: walks sets during INIT, restarts on reset or flush.
    always_ff @(posedge clk) begin
        if (!rst_n || flush)        r_cnt <= '0;
        else if (r_state == ST_INIT) r_cnt <= r_cnt + S_IDX'(1);
    end

    // Storage write port: sweep clears a set, otherwise apply write-back.
    // NOTE: the arrays carry no reset; the INIT sweep is what clears them,
    // which keeps the reset net off every storage flop.
    always_ff @(posedge clk) begin
        if (w_sweep_wr) begin
            r_lru[r_cnt]   <= PLRU_INIT;
            r_valid[r_cnt] <= '0;
        end else if (w_upd_wr) begin
            r_lru[upd_set]   <= upd_state;
            r_valid[upd_set] <= r_valid[upd_set] | upd_way;
        end
    end

    // Lookup read path with write-first bypass and victim selection.
    always_comb begin
        w_bypass        = w_upd_wr && (upd_set == rd_set);
        w_rd_state      = w_bypass ? upd_state : r_lru[rd_set];
        w_rd_valid_bits = r_valid[rd_set] | (w_bypass ? upd_way : '0);
        w_valid4        = '0;
        w_valid4[NUM_WAYS-1:0] = w_rd_valid_bits;
        w_victim4       = plru_victim(w_rd_state, w_valid4, NUM_WAYS);
    end

    // Lookup output registers: load on an accepted lookup, hold otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_valid   <= 1'b0;
            r_lru_out    <= PLRU_INIT;
            r_valid_out  <= '0;
            r_victim_out <= '0;
        end else begin
            r_rd_valid <= w_rd_fire;
            if (w_rd_fire) begin
                r_lru_out    <= w_rd_state;
                r_valid_out  <= w_rd_valid_bits;
                r_victim_out <= w_victim4[NUM_WAYS-1:0];
            end
        end
    end

    assign rd_valid     = r_rd_valid;
    assign lru_curstate = r_lru_out;
    assign valid_out    = r_valid_out;
    assign victim_way   = r_victim_out;

endmodule

// File: tb/tb_plru_state_array.sv
// Directed bench for plru_state_array: a 16-set 4-way instance and a
// 4-set 2-way instance, checked against hand-computed expected values.
module tb_plru_state_array;

    logic       clk = 1'b0;
    logic       rst_n;

    // 4-way instance
    logic       flush, rd_en, upd_en;
    logic [3:0] rd_set, upd_set;
    logic [2:0] upd_state;
    logic [3:0] upd_way;
    logic       ready, rd_valid;
    logic [2:0] lru_curstate;
    logic [3:0] valid_out, victim_way;

    // 2-way instance
    logic       b_flush, b_rd_en, b_upd_en;
    logic [1:0] b_rd_set, b_upd_set;
    logic [2:0] b_upd_state;
    logic [1:0] b_upd_way;
    logic       b_ready, b_rd_valid;
    logic [2:0] b_lru_curstate;
    logic [1:0] b_valid_out, b_victim_way;

    int n_checks = 0;
    int n_fail   = 0;

    plru_state_array #(.NUM_SETS(16), .NUM_WAYS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .rd_en(rd_en), .rd_set(rd_set),
        .upd_en(upd_en), .upd_set(upd_set), .upd_state(upd_state), .upd_way(upd_way),
        .ready(ready), .rd_valid(rd_valid), .lru_curstate(lru_curstate),
        .valid_out(valid_out), .victim_way(victim_way)
    );

    plru_state_array #(.NUM_SETS(4), .NUM_WAYS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .flush(b_flush),
        .rd_en(b_rd_en), .rd_set(b_rd_set),
        .upd_en(b_upd_en), .upd_set(b_upd_set), .upd_state(b_upd_state), .upd_way(b_upd_way),
        .ready(b_ready), .rd_valid(b_rd_valid), .lru_curstate(b_lru_curstate),
        .valid_out(b_valid_out), .victim_way(b_victim_way)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [3:0] s, input logic [2:0] st, input logic [3:0] w);
        upd_en = 1'b1; upd_set = s; upd_state = st; upd_way = w;
        tick();
        upd_en = 1'b0; upd_way = '0;
    endtask

    task automatic look(input string tag, input logic [3:0] s, input logic [2:0] est,
                        input logic [3:0] ev, input logic [3:0] evic);
        rd_en = 1'b1; rd_set = s;
        tick();
        rd_en = 1'b0;
        check({tag, "_rdv"}, 32'(rd_valid), 32'd1);
        check({tag, "_st"},  32'(lru_curstate), 32'(est));
        check({tag, "_val"}, 32'(valid_out), 32'(ev));
        check({tag, "_vic"}, 32'(victim_way), 32'(evic));
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic b_upd(input logic [1:0] s, input logic [2:0] st, input logic [1:0] w);
        b_upd_en = 1'b1; b_upd_set = s; b_upd_state = st; b_upd_way = w;
        tick();
        b_upd_en = 1'b0; b_upd_way = '0;
    endtask

    task automatic b_look(input string tag, input logic [1:0] s, input logic [1:0] ev,
                          input logic [1:0] evic);
        b_rd_en = 1'b1; b_rd_set = s;
        tick();
        b_rd_en = 1'b0;
        check({tag, "_rdv"}, 32'(b_rd_valid), 32'd1);
        check({tag, "_val"}, 32'(b_valid_out), 32'(ev));
        check({tag, "_vic"}, 32'(b_victim_way), 32'(evic));
    endtask

    initial begin
        int n;
        int rdv_seen;

        rst_n = 1'b0; flush = 1'b0; rd_en = 1'b0; upd_en = 1'b0;
        rd_set = '0; upd_set = '0; upd_state = '0; upd_way = '0;
        b_flush = 1'b0; b_rd_en = 1'b0; b_upd_en = 1'b0;
        b_rd_set = '0; b_upd_set = '0; b_upd_state = '0; b_upd_way = '0;

        tick(); tick();
        check("rst_ready",  32'(ready), 32'd0);
        check("rst_rdv",    32'(rd_valid), 32'd0);
        check("rst_state",  32'(lru_curstate), 32'd0);
        check("rst_valid",  32'(valid_out), 32'd0);
        check("rst_victim", 32'(victim_way), 32'd0);

        // Sweep after reset: ready rises after 16 edges.
        rst_n = 1'b1;
        wait_ready(n);
        check("init_cycles", 32'(n), 32'd16);

        look("init_set9", 4'd9, 3'b000, 4'b0000, 4'b0001);
        tick();
        check("hold_rdv", 32'(rd_valid), 32'd0);
        check("hold_vic", 32'(victim_way), 32'b0001);

        // Fill set 5, then vary the tree state.
        upd(4'd5, 3'b011, 4'b0001);
        upd(4'd5, 3'b110, 4'b0010);
        upd(4'd5, 3'b001, 4'b0100);
        upd(4'd5, 3'b011, 4'b1000);
        look("fill5_011", 4'd5, 3'b011, 4'b1111, 4'b0001);
        upd(4'd5, 3'b110, 4'b0000);
        look("fill5_110", 4'd5, 3'b110, 4'b1111, 4'b0100);
        upd(4'd5, 3'b001, 4'b0000);
        look("fill5_001", 4'd5, 3'b001, 4'b1111, 4'b0010);
        upd(4'd5, 3'b000, 4'b0000);
        look("fill5_000", 4'd5, 3'b000, 4'b1111, 4'b1000);

        // Same-cycle lookup and write-back on set 3: write-first bypass.
        rd_en = 1'b1; rd_set = 4'd3;
        upd_en = 1'b1; upd_set = 4'd3; upd_state = 3'b101; upd_way = 4'b0010;
        tick();
        rd_en = 1'b0; upd_en = 1'b0; upd_way = '0;
        check("byp_rdv", 32'(rd_valid), 32'd1);
        check("byp_st",  32'(lru_curstate), 32'b101);
        check("byp_val", 32'(valid_out), 32'b0010);
        check("byp_vic", 32'(victim_way), 32'b0001);
        look("after_byp3", 4'd3, 3'b101, 4'b0010, 4'b0001);

        // Invalid way 2 wins over the tree decode.
        upd(4'd7, 3'b000, 4'b0001);
        upd(4'd7, 3'b000, 4'b0010);
        upd(4'd7, 3'b000, 4'b1000);
        look("inv7", 4'd7, 3'b000, 4'b1011, 4'b0100);

        // 2-way instance is long since initialised.
        check("b_ready", 32'(b_ready), 32'd1);
        b_upd(2'd0, 3'b001, 2'b01);
        b_look("b_half", 2'd0, 2'b01, 2'b10);
        b_upd(2'd0, 3'b001, 2'b10);
        b_look("b_s001", 2'd0, 2'b11, 2'b01);
        b_upd(2'd0, 3'b000, 2'b00);
        b_look("b_s000", 2'd0, 2'b11, 2'b10);

        // Flush with set 2 full; restart mid-sweep; updates ignored during sweep.
        upd(4'd2, 3'b011, 4'b1111);
        look("pre_flush2", 4'd2, 3'b011, 4'b1111, 4'b0001);
        flush = 1'b1; upd_en = 1'b1; upd_set = 4'd2; upd_state = 3'b111; upd_way = 4'b0001;
        tick();
        flush = 1'b0;
        check("flush_ready", 32'(ready), 32'd0);
        for (int i = 0; i < 5; i++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        rd_en = 1'b1; rd_set = 4'd2;
        rdv_seen = 0;
        n = 0;
        while (!ready && n < 40) begin
            tick();
            n++;
            if (rd_valid) rdv_seen++;
        end
        rd_en = 1'b0; upd_en = 1'b0; upd_way = '0;
        check("flush_cycles", 32'(n), 32'd16);
        check("flush_no_rdv", 32'(rdv_seen), 32'd0);
        look("post_flush2", 4'd2, 3'b000, 4'b0000, 4'b0001);
        look("post_flush5", 4'd5, 3'b000, 4'b0000, 4'b0001);

        // Reset with a lookup in flight discards it.
        rd_en = 1'b1; rd_set = 4'd3; rst_n = 1'b0;
        tick();
        rd_en = 1'b0;
        check("midrst_rdv",   32'(rd_valid), 32'd0);
        check("midrst_ready", 32'(ready), 32'd0);
        rst_n = 1'b1;
        wait_ready(n);
        check("reinit_cycles", 32'(n), 32'd16);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
